// File: rtl/bus_access_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_access_ctl_pkg
// Brief  : Chip encodings and per-chip raster timing constants for the
//          CPU/VIC bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package bus_access_ctl_pkg;

    typedef enum logic [1:0] {
        CHIP_6567R56A = 2'd0,
        CHIP_6567R8   = 2'd1,
        CHIP_6569     = 2'd2,
        CHIP_6572     = 2'd3
    } chip_e;

    localparam int c_ba_lead_default = 3;

    // A zero line length marks an unsupported chip; need() is then forced low.
    function automatic logic [7:0] cycles_per_line(input logic [1:0] chip);
        case (chip_e'(chip))
            CHIP_6567R56A: return 8'd64;
            CHIP_6567R8:   return 8'd65;
            CHIP_6569:     return 8'd63;
            CHIP_6572:     return 8'd65;
            default:       return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] cptr_first(input logic [1:0] chip);
        case (chip_e'(chip))
            CHIP_6567R56A, CHIP_6567R8, CHIP_6569, CHIP_6572: return 8'd14;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] cptr_last(input logic [1:0] chip);
        case (chip_e'(chip))
            CHIP_6567R56A, CHIP_6567R8, CHIP_6569, CHIP_6572: return 8'd53;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] spr0_cyc(input logic [1:0] chip);
        case (chip_e'(chip))
            CHIP_6567R56A: return 8'd58;
            CHIP_6567R8:   return 8'd59;
            CHIP_6569:     return 8'd57;
            CHIP_6572:     return 8'd59;
            default:       return 8'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_access_ctl_need_lut.sv
`default_nettype none
// ============================================================================
// Module : bus_need_lut
// Brief  : Combinational test of whether the VIC steals phi2 of cycle i_cyc.
// Rev    : 1.0 - initial release
// ============================================================================
module bus_need_lut
    import bus_access_ctl_pkg::*;
(
    input  logic [1:0] i_chip,
    input  logic       i_badline,
    input  logic [7:0] i_sprite_dma,
    input  logic [7:0] i_cyc,
    output logic       o_need
);

    logic [7:0] w_len;
    logic [7:0] w_c;
    logic [7:0] w_s0;
    logic [7:0] w_s1;
    logic       w_cptr;
    logic       w_spr;

    // i_cyc is at most L+3, so one conditional subtract wraps it into the line.
    always_comb begin
        w_len  = cycles_per_line(i_chip);
        w_c    = (i_cyc >= w_len) ? i_cyc - w_len : i_cyc;
        w_cptr = i_badline && (w_c >= cptr_first(i_chip)) && (w_c <= cptr_last(i_chip));
        w_spr  = 1'b0;
        w_s0   = 8'd0;
        w_s1   = 8'd0;
        for (int n = 0; n < 8; n++) begin
            w_s0 = spr0_cyc(i_chip) + 8'(2 * n);
            if (w_s0 >= w_len) begin
                w_s0 = w_s0 - w_len;
            end
            w_s1 = w_s0 + 8'd1;
            if (w_s1 >= w_len) begin
                w_s1 = w_s1 - w_len;
            end
            if (i_sprite_dma[n] && ((w_c == w_s0) || (w_c == w_s1))) begin
                w_spr = 1'b1;
            end
        end
        o_need = (w_len != 8'd0) && (w_cptr || w_spr);
    end

endmodule
`default_nettype wire

// File: rtl/bus_access_ctl.sv
`default_nettype none
// ============================================================================
// Module : bus_access_ctl
// Brief  : Per-cycle CPU/VIC bus arbiter driving BA/AEC with the BA-to-AEC lead.
// Rev    : 1.0 - initial release
// ============================================================================
module bus_access_ctl
    import bus_access_ctl_pkg::*;
#(
    parameter int BA_LEAD = c_ba_lead_default
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic       clk_phi,
    input  logic       phi_phase_start_0,
    input  logic [1:0] chip,
    input  logic [6:0] cycle_num,
    input  logic       badline,
    input  logic [7:0] sprite_dma,
    output logic       ba,
    output logic       aec,
    output logic       vic_phi2,
    output logic       steal_early,
    output logic [1:0] ba_low_cnt
);

    // The counter saturates at 3, so any lead above 3 can never be met.
    localparam logic [2:0] c_lead = (BA_LEAD > 3) ? 3'd4 : 3'(BA_LEAD);

    logic [3:0] w_need;
    logic       w_ba_next;
    logic [1:0] w_cnt_next;

    logic       r_ba;
    logic       r_aec;
    logic       r_vic_phi2;
    logic       r_steal_early;
    logic [1:0] r_cnt;
    logic       r_armed;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_need
            bus_need_lut u_need (
                .i_chip       (chip),
                .i_badline    (badline),
                .i_sprite_dma (sprite_dma),
                .i_cyc        ({1'b0, cycle_num} + 8'(k)),
                .o_need       (w_need[k])
            );
        end
    endgenerate

    always_comb begin
        w_ba_next  = ~|w_need;
        w_cnt_next = 2'd0;
        if (!w_ba_next && !r_ba) begin
            w_cnt_next = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
        end
    end

    // r_armed holds off phi2 updates until the first phi1 boundary after reset.
    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            r_ba          <= 1'b1;
            r_aec         <= 1'b0;
            r_vic_phi2    <= 1'b0;
            r_steal_early <= 1'b0;
            r_cnt         <= 2'd0;
            r_armed       <= 1'b0;
        end else if (phi_phase_start_0) begin
            if (!clk_phi) begin
                r_ba          <= w_ba_next;
                r_cnt         <= w_cnt_next;
                r_vic_phi2    <= w_need[0];
                r_steal_early <= w_need[0] && ({1'b0, w_cnt_next} < c_lead);
                r_aec         <= 1'b0;
                r_armed       <= 1'b1;
            end else if (r_armed) begin
                r_aec <= !(r_vic_phi2 && ({1'b0, r_cnt} >= c_lead));
            end
        end
    end

    assign ba          = r_ba;
    assign aec         = r_aec;
    assign vic_phi2    = r_vic_phi2;
    assign steal_early = r_steal_early;
    assign ba_low_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_access_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_access_ctl
// Brief  : Directed and randomized bench for bus_access_ctl on the 6569.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bus_access_ctl;

    localparam int c_len  = 63;
    localparam int c_lead = 3;

    logic       clk_dot4x = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_phi = 1'b0;
    logic       phi_phase_start_0 = 1'b0;
    logic [1:0] chip = 2'd2;
    logic [6:0] cycle_num = 7'd0;
    logic       badline = 1'b0;
    logic [7:0] sprite_dma = 8'd0;
    logic       ba;
    logic       aec;
    logic       vic_phi2;
    logic       steal_early;
    logic [1:0] ba_low_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: m_low counts BA-low cycles without bound.
    bit m_ba = 1'b1;
    bit m_aec = 1'b0;
    bit m_vic = 1'b0;
    bit m_early = 1'b0;
    bit m_armed = 1'b0;
    int m_low = 0;

    always #5 clk_dot4x = ~clk_dot4x;

    bus_access_ctl dut (
        .clk_dot4x         (clk_dot4x),
        .rst_n             (rst_n),
        .clk_phi           (clk_phi),
        .phi_phase_start_0 (phi_phase_start_0),
        .chip              (chip),
        .cycle_num         (cycle_num),
        .badline           (badline),
        .sprite_dma        (sprite_dma),
        .ba                (ba),
        .aec               (aec),
        .vic_phi2          (vic_phi2),
        .steal_early       (steal_early),
        .ba_low_cnt        (ba_low_cnt)
    );

    function automatic bit need_m(input int c);
        int cc;
        bit r;
        cc = c % c_len;
        r = badline && (cc >= 14) && (cc <= 53);
        for (int n = 0; n < 8; n++) begin
            if (sprite_dma[n] && ((cc == (57 + 2 * n) % c_len) || (cc == (58 + 2 * n) % c_len)))
                r = 1'b1;
        end
        return r;
    endfunction

    function automatic int lead_cnt();
        return (m_low > 3) ? 3 : m_low;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string where);
        chk1({where, "_ba"}, ba, m_ba);
        chk1({where, "_aec"}, aec, m_aec);
        chk1({where, "_vic"}, vic_phi2, m_vic);
        chk1({where, "_early"}, steal_early, m_early);
        chk2({where, "_cnt"}, ba_low_cnt, 2'(lead_cnt()));
    endtask

    task automatic model_phi1();
        int c;
        bit bn;
        c  = int'(cycle_num);
        bn = !(need_m(c) || need_m(c + 1) || need_m(c + 2) || need_m(c + 3));
        if (bn || m_ba) m_low = 0;
        else m_low++;
        m_ba    = bn;
        m_vic   = need_m(c);
        m_early = m_vic && (lead_cnt() < c_lead);
        m_aec   = 1'b0;
        m_armed = 1'b1;
    endtask

    task automatic model_phi2();
        if (m_armed) m_aec = !(m_vic && (lead_cnt() >= c_lead));
    endtask

    // One phi half-cycle: 4 dot4x clocks, pulse on the first.
    task automatic half(input logic ph);
        clk_phi = ph;
        phi_phase_start_0 = 1'b1;
        @(posedge clk_dot4x);
        #1;
        phi_phase_start_0 = 1'b0;
        if (!ph) model_phi1();
        else model_phi2();
        check_model($sformatf("c%0d_%s", cycle_num, ph ? "p2" : "p1"));
        repeat (3) @(posedge clk_dot4x);
        #1;
    endtask

    task automatic cyc_run(input int c);
        cycle_num = 7'(c);
        half(1'b0);
        half(1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk_dot4x);
        #1;
        m_ba = 1'b1; m_aec = 1'b0; m_vic = 1'b0; m_early = 1'b0; m_low = 0; m_armed = 1'b0;
        chk1("rst_ba", ba, 1'b1);
        chk1("rst_aec", aec, 1'b0);
        chk1("rst_vic", vic_phi2, 1'b0);
        chk1("rst_early", steal_early, 1'b0);
        chk2("rst_cnt", ba_low_cnt, 2'd0);
        repeat (2) @(posedge clk_dot4x);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset, then a stray phi2 boundary that must not release the block.
        do_reset();
        cycle_num = 7'd0;
        half(1'b1);
        chk1("pre_arm_aec", aec, 1'b0);

        // Badline for the whole line, no sprites.
        badline = 1'b1;
        for (int c = 0; c < c_len; c++) begin
            cyc_run(c);
            chk1($sformatf("bl_ba@%0d", c), ba, (c >= 11 && c <= 53) ? 1'b0 : 1'b1);
            chk1($sformatf("bl_aec@%0d", c), aec, (c >= 14 && c <= 53) ? 1'b0 : 1'b1);
            chk1($sformatf("bl_early@%0d", c), steal_early, 1'b0);
            if (c == 14) chk2("bl_cnt@14", ba_low_cnt, 2'd3);
        end
        badline = 1'b0;

        // Sprite 0, then sprite 3 across the line wrap.
        sprite_dma = 8'h01;
        for (int c = 0; c < c_len; c++) begin
            if (c == 59) sprite_dma = 8'h08;
            cyc_run(c);
            if (c <= 58) begin
                chk1($sformatf("s0_ba@%0d", c), ba, (c >= 54) ? 1'b0 : 1'b1);
                chk1($sformatf("s0_aec@%0d", c), aec, (c == 57 || c == 58) ? 1'b0 : 1'b1);
            end else begin
                chk1($sformatf("s3_ba@%0d", c), ba, (c >= 60) ? 1'b0 : 1'b1);
            end
        end
        for (int c = 0; c < c_len; c++) begin
            if (c == 6) sprite_dma = 8'h00;
            cyc_run(c);
            if (c <= 5) begin
                chk1($sformatf("s3_ba@%0d", c), ba, (c <= 1) ? 1'b0 : 1'b1);
                chk1($sformatf("s3_aec@%0d", c), aec, (c <= 1) ? 1'b0 : 1'b1);
                chk1($sformatf("s3_early@%0d", c), steal_early, 1'b0);
            end
        end

        // Late badline raised at cycle 20.
        for (int c = 0; c < c_len; c++) begin
            if (c == 20) badline = 1'b1;
            cyc_run(c);
            if (c == 20) chk1("late_ba@20", ba, 1'b0);
            if (c >= 20 && c <= 22) begin
                chk1($sformatf("late_early@%0d", c), steal_early, 1'b1);
                chk1($sformatf("late_aec@%0d", c), aec, 1'b1);
            end else if (c >= 23 && c <= 53) begin
                chk1($sformatf("late_early@%0d", c), steal_early, 1'b0);
                chk1($sformatf("late_aec@%0d", c), aec, 1'b0);
            end
        end

        // All sprites plus badline: sprites wrap into the next line's c-window.
        sprite_dma = 8'hFF;
        for (int c = 0; c < c_len; c++) begin
            cyc_run(c);
            if (c >= 11) chk1($sformatf("mrg_ba@%0d", c), ba, 1'b0);
            if (c >= 14) chk2($sformatf("mrg_cnt@%0d", c), ba_low_cnt, 2'd3);
        end
        badline = 1'b0;
        for (int c = 0; c < c_len; c++) begin
            cyc_run(c);
            if (c <= 9) begin
                chk1($sformatf("mrg_ba@%0d", c), ba, 1'b0);
                chk2($sformatf("mrg_cnt@%0d", c), ba_low_cnt, 2'd3);
            end
        end

        // Randomized badline/sprite activity against the reference model.
        for (int line = 0; line < 4; line++) begin
            for (int c = 0; c < c_len; c++) begin
                if ($urandom_range(0, 15) == 0) badline = ~badline;
                if ($urandom_range(0, 20) == 0) sprite_dma = 8'($urandom);
                cyc_run(c);
            end
        end

        // Reset in the middle of a badline steal; the lead restarts from zero.
        badline = 1'b1;
        sprite_dma = 8'h00;
        for (int c = 0; c < 30; c++) cyc_run(c);
        cycle_num = 7'd30;
        half(1'b0);
        do_reset();
        for (int c = 31; c < c_len; c++) begin
            cyc_run(c);
            if (c <= 34) begin
                chk1($sformatf("post_rst_early@%0d", c), steal_early, (c <= 33) ? 1'b1 : 1'b0);
                chk1($sformatf("post_rst_aec@%0d", c), aec, (c <= 33) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
